// File: rtl/chunk_source.sv
// chunk_source: responder end of the 32-bit chunk-streaming handshake.
// Holds a host-loaded key (8 words), nonce (3 words) and block counter.
// Each accepted chunk_request is answered with the addressed word after a
// fixed LATENCY. The counter word can optionally advance after each delivery.
module chunk_source #(
    parameter int LATENCY  = 2,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        chunk_request,
    input  logic [1:0]  req_type,
    input  logic [4:0]  chunk_index,
    output logic        chunk_valid,
    output logic [1:0]  chunk_type,
    output logic [31:0] chunk,
    output logic        chunk_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [31:0] key_q [8];
    logic [31:0] nonce_q [3];
    logic [31:0] ctr_q;

    logic [31:0] snap_q;
    logic [1:0]  snap_type_q;
    logic [31:0] chunk_q;
    logic [1:0]  type_q;
    logic        err_q;

    logic        req_ok;
    logic [31:0] rd_word;
    logic        accept_ok;
    logic        accept_bad;
    logic        enter_serve;
    logic        serve_inc;

    // Decide whether the requested (type, index) pair names a stored word.
    always_comb begin
        req_ok = 1'b0;
        case (req_type)
            2'd0:    req_ok = (chunk_index < 5'd8);
            2'd1:    req_ok = (chunk_index < 5'd3);
            2'd2:    req_ok = (chunk_index == 5'd0);
            default: req_ok = 1'b0;
        endcase
    end

    // Read mux selecting the addressed storage word.
    always_comb begin
        rd_word = '0;
        case (req_type)
            2'd0: rd_word = key_q[chunk_index[2:0]];
            2'd1: begin
                case (chunk_index[1:0])
                    2'd0:    rd_word = nonce_q[0];
                    2'd1:    rd_word = nonce_q[1];
                    2'd2:    rd_word = nonce_q[2];
                    default: rd_word = '0;
                endcase
            end
            2'd2:    rd_word = ctr_q;
            default: rd_word = '0;
        endcase
    end

    // Next-state logic: accept/reject in IDLE, count down in WAIT, one SERVE cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept_ok   = 1'b0;
        accept_bad  = 1'b0;
        enter_serve = 1'b0;
        case (state_q)
            IDLE: begin
                if (chunk_request) begin
                    if (req_ok) begin
                        accept_ok = 1'b1;
                        if (LATENCY == 1) begin
                            state_d     = SERVE;
                            enter_serve = 1'b1;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = 4'(LATENCY - 1);
                        end
                    end else begin
                        accept_bad = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d     = SERVE;
                    enter_serve = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SERVE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Snapshot at accept so later host writes cannot disturb an in-flight word;
    // the visible output only changes when a delivery starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q      <= '0;
            snap_type_q <= '0;
            chunk_q     <= '0;
            type_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= accept_bad;
            if (accept_ok) begin
                snap_q      <= rd_word;
                snap_type_q <= req_type;
            end
            if (enter_serve) begin
                chunk_q <= (state_q == IDLE) ? rd_word  : snap_q;
                type_q  <= (state_q == IDLE) ? req_type : snap_type_q;
            end
        end
    end

    // Counter advances on the edge leaving a counter delivery.
    assign serve_inc = AUTO_INC && (state_q == SERVE) && (type_q == 2'd2);

    // Host-writable storage; a host write to the counter beats the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) key_q[i] <= '0;
            for (int i = 0; i < 3; i++) nonce_q[i] <= '0;
            ctr_q <= '0;
        end else begin
            if (cfg_we && !cfg_addr[3]) key_q[cfg_addr[2:0]] <= cfg_wdata;
            if (cfg_we && cfg_addr == 4'd8)  nonce_q[0] <= cfg_wdata;
            if (cfg_we && cfg_addr == 4'd9)  nonce_q[1] <= cfg_wdata;
            if (cfg_we && cfg_addr == 4'd10) nonce_q[2] <= cfg_wdata;
            if (cfg_we && cfg_addr == 4'd11) ctr_q <= cfg_wdata;
            else if (serve_inc)              ctr_q <= ctr_q + 32'd1;
        end
    end

    assign chunk_valid = (state_q == SERVE);
    assign busy        = (state_q != IDLE);
    assign chunk       = chunk_q;
    assign chunk_type  = type_q;
    assign chunk_error = err_q;

endmodule

// File: tb/tb_chunk_source.sv
// tb_chunk_source: randomized self-checking bench for chunk_source against a
// field-level storage model (key/nonce/counter arrays).
module tb_chunk_source;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        chunk_request;
    logic [1:0]  req_type;
    logic [4:0]  chunk_index;

    logic        chunk_valid, chunk_error, busy;
    logic [1:0]  chunk_type;
    logic [31:0] chunk;

    logic        s_valid, s_error, s_busy;
    logic [1:0]  s_type;
    logic [31:0] s_chunk;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_key [8];
    logic [31:0] m_nonce [3];
    logic [31:0] m_ctr;

    chunk_source #(.LATENCY(LAT), .AUTO_INC(1'b1)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .chunk_request(chunk_request),
        .req_type(req_type), .chunk_index(chunk_index),
        .chunk_valid(chunk_valid), .chunk_type(chunk_type), .chunk(chunk),
        .chunk_error(chunk_error), .busy(busy)
    );

    chunk_source #(.LATENCY(LAT), .AUTO_INC(1'b0)) dut_static (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .chunk_request(chunk_request),
        .req_type(req_type), .chunk_index(chunk_index),
        .chunk_valid(s_valid), .chunk_type(s_type), .chunk(s_chunk),
        .chunk_error(s_error), .busy(s_busy)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_key[i] = '0;
        for (int i = 0; i < 3; i++) m_nonce[i] = '0;
        m_ctr = '0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d);
        if (a < 4'd8)       m_key[a[2:0]] = d;
        else if (a < 4'd11) m_nonce[a - 4'd8] = d;
        else if (a == 4'd11) m_ctr = d;
    endtask

    function automatic bit model_ok(input logic [1:0] t, input logic [4:0] i);
        return (t == 2'd0 && i < 5'd8) || (t == 2'd1 && i < 5'd3) || (t == 2'd2 && i == 5'd0);
    endfunction

    function automatic logic [31:0] model_word(input logic [1:0] t, input logic [4:0] i);
        if (t == 2'd0) return m_key[i[2:0]];
        if (t == 2'd1) return m_nonce[i[1:0]];
        return m_ctr;
    endfunction

    // All tasks start and end just after a falling edge with inputs idle.
    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        model_write(a, d);
    endtask

    task automatic do_req(input logic [1:0] t, input logic [4:0] i);
        bit          ok;
        logic [31:0] w;
        ok = model_ok(t, i);
        w  = model_word(t, i);
        chunk_request = 1'b1; req_type = t; chunk_index = i;
        @(negedge clk);
        chunk_request = 1'b0;
        if (!ok) begin
            total++;
            if (chunk_error !== 1'b1) begin bad++; $display("FAIL err_pulse t=%0d i=%0d got=%b want=1", t, i, chunk_error); end
            total++;
            if (busy !== 1'b0 || chunk_valid !== 1'b0) begin bad++; $display("FAIL err_quiet t=%0d i=%0d busy=%b valid=%b want 0/0", t, i, busy, chunk_valid); end
            @(negedge clk);
            total++;
            if (chunk_error !== 1'b0 || chunk_valid !== 1'b0) begin bad++; $display("FAIL err_once t=%0d i=%0d err=%b valid=%b want 0/0", t, i, chunk_error, chunk_valid); end
        end else begin
            for (int c = 1; c <= LAT + 2; c++) begin
                total++;
                if (chunk_error !== 1'b0) begin bad++; $display("FAIL spurious_err t=%0d i=%0d c=%0d", t, i, c); end
                if (c < LAT) begin
                    total++;
                    if (busy !== 1'b1 || chunk_valid !== 1'b0) begin bad++; $display("FAIL wait t=%0d c=%0d busy=%b valid=%b want 1/0", t, c, busy, chunk_valid); end
                end else if (c == LAT) begin
                    total++;
                    if (chunk_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL serve t=%0d i=%0d valid=%b busy=%b want 1/1", t, i, chunk_valid, busy); end
                    total++;
                    if (chunk !== w) begin bad++; $display("FAIL data t=%0d i=%0d got=%h want=%h", t, i, chunk, w); end
                    total++;
                    if (chunk_type !== t) begin bad++; $display("FAIL type got=%0d want=%0d", chunk_type, t); end
                end else begin
                    total++;
                    if (chunk_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_after t=%0d c=%0d valid=%b busy=%b want 0/0", t, c, chunk_valid, busy); end
                    total++;
                    if (chunk !== w) begin bad++; $display("FAIL hold got=%h want=%h", chunk, w); end
                end
                if (c < LAT + 2) @(negedge clk);
            end
            if (t == 2'd2) m_ctr = m_ctr + 32'd1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        chunk_request = 1'b0; req_type = '0; chunk_index = '0;
        model_clear();
        @(negedge clk); @(negedge clk);
        total++;
        if ({chunk_valid, chunk_error, busy, chunk_type, chunk} !== '0) begin
            bad++; $display("FAIL reset_outputs got v=%b e=%b b=%b t=%0d c=%h want all 0", chunk_valid, chunk_error, busy, chunk_type, chunk);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 12; a++) host_write(4'(a), $urandom | 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        do_req(2'd0, 5'd3);
        do_req(2'd1, 5'd2);
        do_req(2'd2, 5'd0);
    endtask

    task automatic test_key_fetch();
        for (int i = 0; i < 8; i++) host_write(4'(i), 32'h00010203 + 32'h04040404 * i);
        do_req(2'd0, 5'd5);
        do_req(2'd0, 5'd0);
        do_req(2'd0, 5'd7);
    endtask

    task automatic test_back_to_back();
        logic [1:0] st [12];
        logic [4:0] si [12];
        int k = 0, last = -1, cyc = 0;
        for (int n = 0; n < 3; n++) host_write(4'(8 + n), $urandom);
        host_write(4'd11, $urandom);
        for (int n = 0; n < 12; n++) begin
            st[n] = (n < 8) ? 2'd0 : (n < 11) ? 2'd1 : 2'd2;
            si[n] = (n < 8) ? 5'(n) : (n < 11) ? 5'(n - 8) : 5'd0;
        end
        chunk_request = 1'b1; req_type = st[0]; chunk_index = si[0];
        while (k < 12 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            total++;
            if (chunk_error !== 1'b0) begin bad++; $display("FAIL b2b_err cyc=%0d", cyc); end
            if (chunk_valid === 1'b1) begin
                total++;
                if (chunk !== model_word(st[k], si[k]) || chunk_type !== st[k]) begin
                    bad++; $display("FAIL b2b_data k=%0d got=%h/%0d want=%h/%0d", k, chunk, chunk_type, model_word(st[k], si[k]), st[k]);
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last != LAT + 1) begin bad++; $display("FAIL b2b_gap k=%0d got=%0d want=%0d", k, cyc - last, LAT + 1); end
                end
                if (st[k] == 2'd2) m_ctr = m_ctr + 32'd1;
                last = cyc;
                k++;
                if (k < 12) begin req_type = st[k]; chunk_index = si[k]; end
                else chunk_request = 1'b0;
            end
        end
        chunk_request = 1'b0;
        total++;
        if (k != 12) begin bad++; $display("FAIL b2b_count got=%0d want=12", k); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_auto_inc_wrap();
        host_write(4'd11, 32'hFFFFFFFF);
        do_req(2'd2, 5'd0);
        total++;
        if (s_chunk !== 32'hFFFFFFFF) begin bad++; $display("FAIL static_ctr1 got=%h want=ffffffff", s_chunk); end
        do_req(2'd2, 5'd0);
        total++;
        if (s_chunk !== 32'hFFFFFFFF) begin bad++; $display("FAIL static_ctr2 got=%h want=ffffffff", s_chunk); end
    endtask

    task automatic test_invalid();
        do_req(2'd1, 5'd3);
        do_req(2'd3, 5'd0);
        do_req(2'd0, 5'd8);
        do_req(2'd2, 5'd1);
    endtask

    task automatic test_collision();
        logic [31:0] w, v, x;
        host_write(4'd9, 32'h55555555);
        w = model_word(2'd1, 5'd1);
        cfg_we = 1'b1; cfg_addr = 4'd9; cfg_wdata = 32'hAAAAAAAA;
        chunk_request = 1'b1; req_type = 2'd1; chunk_index = 5'd1;
        @(negedge clk);
        cfg_we = 1'b0; chunk_request = 1'b0;
        model_write(4'd9, 32'hAAAAAAAA);
        @(negedge clk);
        total++;
        if (chunk_valid !== 1'b1 || chunk !== w) begin bad++; $display("FAIL coll_nonce valid=%b got=%h want=%h", chunk_valid, chunk, w); end
        @(negedge clk); @(negedge clk);
        do_req(2'd1, 5'd1);
        v = $urandom; x = $urandom;
        host_write(4'd11, v);
        chunk_request = 1'b1; req_type = 2'd2; chunk_index = 5'd0;
        @(negedge clk);
        chunk_request = 1'b0;
        @(negedge clk);
        total++;
        if (chunk_valid !== 1'b1 || chunk !== v) begin bad++; $display("FAIL coll_ctr_serve valid=%b got=%h want=%h", chunk_valid, chunk, v); end
        cfg_we = 1'b1; cfg_addr = 4'd11; cfg_wdata = x;
        @(negedge clk);
        cfg_we = 1'b0;
        m_ctr = x;
        @(negedge clk);
        do_req(2'd2, 5'd0);
    endtask

    task automatic test_random();
        logic [1:0] t;
        logic [4:0] i;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) host_write(4'($urandom_range(0, 15)), $urandom);
            t = 2'($urandom_range(0, 3));
            i = 5'($urandom_range(0, 9));
            do_req(t, i);
        end
    endtask

    task automatic test_reset_mid();
        host_write(4'd0, $urandom | 32'h1);
        do_req(2'd0, 5'd0);
        chunk_request = 1'b1; req_type = 2'd0; chunk_index = 5'd0;
        @(negedge clk);
        chunk_request = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || chunk_valid !== 1'b0 || chunk !== 32'h0) begin
            bad++; $display("FAIL mid_reset busy=%b valid=%b chunk=%h want 0/0/0", busy, chunk_valid, chunk);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (chunk_valid !== 1'b0) begin bad++; $display("FAIL mid_valid c=%0d got=%b want=0", c, chunk_valid); end
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        do_req(2'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_key_fetch();
        test_back_to_back();
        test_auto_inc_wrap();
        test_invalid();
        test_collision();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
